seg_dynamic_scan: RTL
=====================

Name: seg_dynamic_scan

Overview:
- Upstream feeder for hc595_ctrl: it replaces the static pattern source with a 6-digit multiplexed decimal display driver.
- It converts a 20-bit binary value to BCD with a sequential double-dabble converter.
- It applies leading-zero blanking, the sign and the decimal points.
- It time-multiplexes the six digits onto sel/seg at a fixed scan period.
- Outputs connect directly to hc595_ctrl sel/seg.

Parameters:
- CNT_MAX, 49_999: scan counter terminal value; digit dwell = CNT_MAX+1 clocks (1 ms at 50 MHz).
- DIG_NUM, 6: digit count; fixed; the design must not be re-parameterised.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- data  in  20  unsigned value to display; values above 999_999 clamp to 999_999.
- point  in  6  decimal point enables; bit i lights the dp of digit i (digit 0 = rightmost).
- sign  in  1  1 = show '-' ahead of the most significant displayed digit.
- seg_en  in  1  display enable; 0 = all digits dark.
- sel  out  6  one-hot digit select, active-high; bit i = digit i.
- seg  out  8  segment pattern, active-low; bit7 = dp, bits6..0 = g..a.

Behaviour:
- All state is updated on the sys_clk rising edge.
- Reset is synchronous (sys_rst=1), and while it is held:
  - sel = 6'b000000, seg = 8'hFF.
  - Scan counter = 0, digit index = 0.
  - Converter in IDLE; display BCD register = all zero.
- Converter FSM (sub-module):
  - IDLE: capture min(data, 999_999) into the shift register, clear the BCD accumulator, go to SHIFT.
  - SHIFT: exactly 20 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts the {bcd, bin} pair left by 1. After the 20th iteration, go to DONE.
  - DONE: copy the 24-bit BCD into the display register in one cycle (atomic; no partial values are ever visible), then go to IDLE.
  - Period is 22 clocks per conversion.
  - A data change mid-conversion is ignored until the next IDLE sample.
- Scan counter:
  - Counts 0..CNT_MAX and wraps.
  - scan_flag is asserted for the single cycle where count == CNT_MAX.
  - On scan_flag, the digit index advances 0→1→…→5→0.
- Output register:
  - The cycle after the digit index changes, sel = 1<<index and seg = the pattern for that digit.
  - Latency from index change to output is 1 clock.
  - In steady state, sel changes exactly once per CNT_MAX+1 clocks.
- Segment codes:
  - Digits: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - blank FF, minus BF.
  - When point[index]=1, the dp bit is cleared: seg &= 8'h7F (also applies to blank/minus).
- Leading-zero blanking:
  - msd = the highest i with a nonzero BCD nibble, or 0 if the value is 0.
  - Digits i > msd are blank, except any digit with point[j]=1 for some j ≥ i, which shows '0'. This extends msd upward.
- Sign:
  - With sign=1 and effective msd < 5, digit msd+1 shows minus.
  - With msd = 5, sign is ignored.
- seg_en:
  - seg_en=0: sel = 0, seg = FF on the next clock.
  - The scan counter and converter keep running.
  - When seg_en returns to 1, output resumes at the current index on the next clock.
- Reset asserted mid-conversion or mid-dwell: everything returns to reset values the next clock, and the first conversion restarts from IDLE.

Decomposition:
- Package seg_pkg holds:
  - DIG_NUM = 6, BCD width 24, BIN width 20, clamp constant 999_999.
  - Segment code constants SEG_0..SEG_9, SEG_BLANK, SEG_MINUS.
  - The one-hot sel encoding function.
- Sub-module bin2bcd: the sequential double-dabble FSM with ports sys_clk, sys_rst, bin_in[19:0], bcd_out[23:0], bcd_valid. bcd_valid is a 1-cycle pulse in DONE.
- Top of this block: scan counter, blanking/sign logic, output register.

Test Plan:
- Reset then data=123456, point=0, sign=0, seg_en=1, CNT_MAX=9:
  - After the first conversion (22 clks), sel cycles 01,02,04,08,10,20 every 10 clks.
  - seg sequence: 82,92,99,B0,A4,F9.
- data=42, sign=1: digit0=A4, digit1=99, digit2=BF, digits3–5=FF.
- data=7, point=6'b000100: digit0=F8, digit1=C0, digit2=40 (0 with dp), digits3–5=FF.
- data=20'hFFFFF (1_048_575), sign=1: shows 999999 on all digits (90), no minus.
- seg_en deasserted for 15 clks mid-scan:
  - sel=00, seg=FF the next clock after deassertion.
  - After reassertion, the index continues from its free-running value (no restart).
- sys_rst pulsed during SHIFT with data changed 0→555555:
  - Outputs are 00/FF the next clock.
  - The display shows 555555 once the first post-reset conversion completes (22 clks later).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, segment codes and helpers for the six-digit scan display.
// Latency: none (package only).
// Backpressure: none.
package seg_pkg;

    localparam int DIG_NUM = 6;
    localparam int BCD_W   = 24;
    localparam int BIN_W   = 20;

    // Largest value that fits in six decimal digits.
    localparam logic [BIN_W-1:0] BIN_CLAMP = 20'd999_999;

    // Active-low segment codes, bit7 = dp, bits6..0 = g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    // One-hot digit select; indices beyond the last digit give all zeros.
    function automatic logic [DIG_NUM-1:0] sel_onehot(input logic [2:0] idx);
        logic [DIG_NUM-1:0] v;
        for (int i = 0; i < DIG_NUM; i++) begin
            v[i] = (idx == i[2:0]);
        end
        return v;
    endfunction

    function automatic logic [7:0] seg_digit(input logic [3:0] nib);
        logic [7:0] c;
        case (nib)
            4'd0:    c = SEG_0;
            4'd1:    c = SEG_1;
            4'd2:    c = SEG_2;
            4'd3:    c = SEG_3;
            4'd4:    c = SEG_4;
            4'd5:    c = SEG_5;
            4'd6:    c = SEG_6;
            4'd7:    c = SEG_7;
            4'd8:    c = SEG_8;
            4'd9:    c = SEG_9;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: clamps a 20-bit binary value and converts it to 6 BCD digits.
// Latency: 22 clocks per conversion (IDLE 1, SHIFT 20, DONE 1), free-running back to back.
// Backpressure: none; bcd_out is only meaningful while bcd_valid pulses (the DONE cycle).
// Ports: sys_clk, sys_rst (sync, active-high), bin_in (sampled in IDLE only),
//        bcd_out (accumulator), bcd_valid (1-cycle pulse in DONE).
module bin2bcd
    import seg_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             bcd_valid
);

    conv_state_t      r_state;
    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [4:0]       r_iter;
    logic             r_valid;
    logic [BCD_W-1:0] w_bcd_adj;

    // Add-3 correction on every nibble that would overflow past 9 after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIG_NUM; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= CONV_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                CONV_IDLE: begin
                    r_bin   <= (bin_in > BIN_CLAMP) ? BIN_CLAMP : bin_in;
                    r_bcd   <= '0;
                    r_iter  <= '0;
                    r_valid <= 1'b0;
                    r_state <= CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    // Shift {bcd, bin} left by one after correction.
                    r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
                    r_iter <= r_iter + 5'd1;
                    if (r_iter == 5'd19) begin
                        r_valid <= 1'b1;
                        r_state <= CONV_DONE;
                    end
                end
                CONV_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= CONV_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= CONV_IDLE;
                end
            endcase
        end
    end

    assign bcd_out   = r_bcd;
    assign bcd_valid = r_valid;

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed decimal display driver feeding hc595_ctrl sel/seg.
// Latency: 1 clock from digit-index change (or seg_en change) to sel/seg; new data shows within 2 conversions.
// Backpressure: none; free-running scan, seg_en only gates the outputs.
// Ports: sys_clk, sys_rst (sync, active-high), data[19:0] (clamped to 999_999), point[5:0] (dp per digit),
//        sign (minus ahead of msd), seg_en (0 = dark), sel[5:0] (one-hot, active-high), seg[7:0] (active-low).
module seg_dynamic_scan
    import seg_pkg::*;
#(
    parameter int CNT_MAX = 49_999
)
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [BIN_W-1:0]   data,
    input  logic [DIG_NUM-1:0] point,
    input  logic               sign,
    input  logic               seg_en,
    output logic [DIG_NUM-1:0] sel,
    output logic [7:0]         seg
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [BCD_W-1:0]   r_disp;
    logic [DIG_NUM-1:0] r_sel;
    logic [7:0]         r_seg;

    logic [BCD_W-1:0]   w_bcd;
    logic               w_bcd_vld;
    logic               w_scan_flag;
    logic [2:0]         w_eff_msd;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic [7:0]         w_pat;

    bin2bcd u_bin2bcd (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bin_in    (data),
        .bcd_out   (w_bcd),
        .bcd_valid (w_bcd_vld)
    );

    assign w_scan_flag = (r_cnt == CNT_W'(CNT_MAX));

    // Effective most-significant digit: highest nonzero nibble, pushed up by
    // any lit decimal point so that digits below a dp show '0' instead of blank.
    always_comb begin
        w_eff_msd = 3'd0;
        for (int i = 1; i < DIG_NUM; i++) begin
            if (r_disp[i*4 +: 4] != 4'd0) begin
                w_eff_msd = 3'(i);
            end
        end
        for (int i = 0; i < DIG_NUM; i++) begin
            if (point[i] && (3'(i) > w_eff_msd)) begin
                w_eff_msd = 3'(i);
            end
        end
    end

    // Pattern for the digit currently selected. With msd = 5 the minus slot
    // would be digit 6, which never matches, so sign drops out naturally.
    always_comb begin
        w_nib = 4'd0;
        w_dp  = 1'b0;
        for (int i = 0; i < DIG_NUM; i++) begin
            if (r_idx == 3'(i)) begin
                w_nib = r_disp[i*4 +: 4];
                w_dp  = point[i];
            end
        end
        if (r_idx <= w_eff_msd) begin
            w_pat = seg_digit(w_nib);
        end else if (sign && (r_idx == w_eff_msd + 3'd1)) begin
            w_pat = SEG_MINUS;
        end else begin
            w_pat = SEG_BLANK;
        end
        if (w_dp) begin
            w_pat = w_pat & 8'h7F;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_disp <= '0;
            r_sel  <= '0;
            r_seg  <= SEG_BLANK;
        end else begin
            r_cnt <= w_scan_flag ? '0 : r_cnt + 1'b1;
            if (w_scan_flag) begin
                r_idx <= (r_idx == 3'(DIG_NUM - 1)) ? 3'd0 : r_idx + 3'd1;
            end
            // Whole 24-bit result lands at once, so no half-converted value is shown.
            if (w_bcd_vld) begin
                r_disp <= w_bcd;
            end
            r_sel <= seg_en ? sel_onehot(r_idx) : '0;
            r_seg <= seg_en ? w_pat : SEG_BLANK;
        end
    end

    assign sel = r_sel;
    assign seg = r_seg;

endmodule
